monitor_verdict_collector: RTL and testbench

Sink-side companion to the generated `topEntity` monitor: samples the monitor's per-output value/active pairs every enabled clock, timestamps each cycle that has at least one active output, buffers the record in an internal FIFO, and streams it out as a sequence of DATA_W-bit words over a valid/ready link. It replaces ad-hoc `$display` scraping in end-to-end runs and is the hardware path for verdicts leaving the FPGA.

---
 rtl/monitor_verdict_collector.sv | 155 +++++++++++++++
 tb/tb_monitor_verdict_collector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_verdict_collector.sv
// Captures per-cycle monitor verdicts with a timestamp into a record FIFO and
// streams each record out as a header word followed by the active stream values.
module monitor_verdict_collector #(
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_value,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic [DATA_W-1:0]         rec_data,
  output logic                      rec_valid,
  output logic                      rec_last,
  input  logic                      rec_ready,
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [LW-1:0] Full = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StHead, StData} state_e;

  state_e state_q, state_d;

  logic [TS_W-1:0]           ts_q;
  logic [TS_W-1:0]           ts_mem   [DEPTH];
  logic [NUM_OUT-1:0]        mask_mem [DEPTH];
  logic [NUM_OUT*DATA_W-1:0] val_mem  [DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]             level_q;

  logic [TS_W-1:0]           sh_ts_q;
  logic [NUM_OUT-1:0]        sh_mask_q;
  logic [NUM_OUT*DATA_W-1:0] sh_vals_q;
  logic [IW-1:0]             idx_q;

  logic          push_req, push, pop, hs, is_last;
  logic [IW-1:0] first_idx, last_idx, next_idx;

  assign push_req   = en & (|out_aktv);
  assign pop        = (state_q == StIdle) && (level_q != '0);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push       = push_req && ((level_q != Full) || pop);
  assign hs         = rec_valid & rec_ready;
  assign is_last    = (idx_q == last_idx);
  assign fifo_level = level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (en) ts_q <= ts_q + TS_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_ptr_q]   <= ts_q;
      mask_mem[wr_ptr_q] <= out_aktv;
      val_mem[wr_ptr_q]  <= out_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_ts_q   <= '0;
      sh_mask_q <= '0;
      sh_vals_q <= '0;
      idx_q     <= '0;
    end else begin
      if (pop) begin
        sh_ts_q   <= ts_mem[rd_ptr_q];
        sh_mask_q <= mask_mem[rd_ptr_q];
        sh_vals_q <= val_mem[rd_ptr_q];
      end
      if (state_q == StHead && hs) begin
        idx_q <= first_idx;
      end else if (state_q == StData && hs && !is_last) begin
        idx_q <= next_idx;
      end
    end
  end

  // Lowest, highest and next-higher set bits of the held mask.
  always_comb begin
    first_idx = '0;
    last_idx  = '0;
    next_idx  = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (sh_mask_q[i]) first_idx = IW'(i);
      if (sh_mask_q[i] && (i > int'(idx_q))) next_idx = IW'(i);
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      if (sh_mask_q[i]) last_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (level_q != '0) state_d = StHead;
      StHead:  if (rec_ready) state_d = StData;
      StData:  if (rec_ready && is_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rec_valid = 1'b0;
    rec_last  = 1'b0;
    rec_data  = '0;
    unique case (state_q)
      StHead: begin
        rec_valid                   = 1'b1;
        rec_data[DATA_W-1 -: TS_W]  = sh_ts_q;
        rec_data[NUM_OUT-1:0]       = sh_mask_q;
      end
      StData: begin
        rec_valid = 1'b1;
        rec_last  = is_last;
        rec_data  = sh_vals_q[idx_q*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_monitor_verdict_collector.sv
// Random and directed checks of two collectors (32-bit and 4-bit timestamps)
// sharing one stimulus stream, against a record/word queue model.
module tb_monitor_verdict_collector;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            rec_ready = 1'b0;
  logic [N*DW-1:0] out_value = '0;
  logic [N-1:0]    out_aktv = '0;

  logic [DW-1:0] a_data, b_data;
  logic          a_valid, a_last, b_valid, b_last, a_ovf, b_ovf;
  logic [15:0]   a_drop, b_drop;
  logic [3:0]    a_lvl, b_lvl;

  always #5 clk = ~clk;

  monitor_verdict_collector #(.NUM_OUT(N), .DATA_W(DW), .TS_W(32), .DEPTH(D)) u_a (
    .clk(clk), .rst(rst), .en(en), .out_value(out_value), .out_aktv(out_aktv),
    .rec_data(a_data), .rec_valid(a_valid), .rec_last(a_last), .rec_ready(rec_ready),
    .overflow(a_ovf), .drop_count(a_drop), .fifo_level(a_lvl)
  );

  monitor_verdict_collector #(.NUM_OUT(N), .DATA_W(DW), .TS_W(4), .DEPTH(D)) u_b (
    .clk(clk), .rst(rst), .en(en), .out_value(out_value), .out_aktv(out_aktv),
    .rec_data(b_data), .rec_valid(b_valid), .rec_last(b_last), .rec_ready(rec_ready),
    .overflow(b_ovf), .drop_count(b_drop), .fifo_level(b_lvl)
  );

  typedef struct packed {
    logic [31:0]     ts;
    logic [N-1:0]    mask;
    logic [N*DW-1:0] vals;
  } rec_t;

  typedef struct packed {
    logic          is_hdr;
    logic [31:0]   ts;
    logic [N-1:0]  mask;
    logic [DW-1:0] val;
    logic          last;
  } word_t;

  rec_t        mq[$];
  word_t       wq[$];
  logic [31:0] m_ts = '0;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input word_t w, input int tw);
    logic [63:0] d;
    d = '0;
    if (!w.is_hdr) return w.val;
    for (int b = 0; b < tw; b++) d[64-tw+b] = w.ts[b];
    d[N-1:0] = w.mask;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    wq.delete();
    m_ts   = '0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge: drain/pop using pre-edge state, then capture.
  task automatic model_step();
    bit    popping;
    int    pre;
    rec_t  r;
    word_t w;
    popping = (wq.size() == 0) && (mq.size() != 0);
    pre     = mq.size();
    if (wq.size() != 0 && rec_ready) w = wq.pop_front();
    if (popping) begin
      r = mq.pop_front();
      w = '0;
      w.is_hdr = 1'b1;
      w.ts     = r.ts;
      w.mask   = r.mask;
      wq.push_back(w);
      for (int i = 0; i < N; i++) begin
        if (r.mask[i]) begin
          w      = '0;
          w.val  = r.vals[i*DW +: DW];
          w.last = ((r.mask >> (i + 1)) == 0);
          wq.push_back(w);
        end
      end
    end
    if (en && out_aktv != 0) begin
      if (pre < D || popping) begin
        r.ts   = m_ts;
        r.mask = out_aktv;
        r.vals = out_value;
        mq.push_back(r);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (en) m_ts++;
  endtask

  task automatic compare_all();
    word_t w;
    bit    ev;
    ev = (wq.size() != 0);
    w  = '0;
    if (ev) w = wq[0];
    chk("a_valid", 64'(a_valid), 64'(ev));
    chk("b_valid", 64'(b_valid), 64'(ev));
    if (ev) begin
      chk("a_data", a_data, exp_data(w, 32));
      chk("b_data", b_data, exp_data(w, 4));
      chk("a_last", 64'(a_last), 64'(w.last));
      chk("b_last", 64'(b_last), 64'(w.last));
    end
    chk("a_level", 64'(a_lvl), 64'(mq.size()));
    chk("b_level", 64'(b_lvl), 64'(mq.size()));
    chk("a_drop", 64'(a_drop), 64'(m_drop));
    chk("b_drop", 64'(b_drop), 64'(m_drop));
    chk("a_ovf", 64'(a_ovf), 64'(m_ovf));
    chk("b_ovf", 64'(b_ovf), 64'(m_ovf));
  endtask

  always @(negedge clk) compare_all();

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid"}, 64'(a_valid), 64'd0);
    chk({nm, "_last"}, 64'(a_last), 64'd0);
    chk({nm, "_data"}, a_data, 64'd0);
    chk({nm, "_level"}, 64'(a_lvl), 64'd0);
    chk({nm, "_drop"}, 64'(a_drop), 64'd0);
    chk({nm, "_ovf"}, 64'(a_ovf), 64'd0);
  endtask

  initial begin
    #2;
    chk_reset_state("por");
    #10 rst = 1'b1;

    // Single event at ts=500.
    en = 1'b1;
    rec_ready = 1'b1;
    repeat (500) step();
    out_aktv  = 3'b101;
    out_value = {64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7};
    step();
    out_aktv = '0;
    chk("single_no_valid_yet", 64'(a_valid), 64'd0);
    chk("single_level1", 64'(a_lvl), 64'd1);
    step();
    chk("single_valid", 64'(a_valid), 64'd1);
    chk("single_hdr_a", a_data, 64'h0000_01F4_0000_0005);
    chk("single_hdr_b", b_data, 64'h4000_0000_0000_0005);
    step();
    chk("single_w1", a_data, 64'd7);
    step();
    chk("single_w2", a_data, 64'd9);
    chk("single_w2_last", 64'(a_last), 64'd1);
    step();
    chk("single_done_valid", 64'(a_valid), 64'd0);
    chk("single_done_level", 64'(a_lvl), 64'd0);

    // Backpressure on the second word.
    out_aktv = 3'b101;
    step();
    out_aktv = '0;
    step();
    step();
    rec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data", a_data, 64'd7);
      chk("bp_hold_valid", 64'(a_valid), 64'd1);
    end
    rec_ready = 1'b1;
    step();
    chk("bp_w2", a_data, 64'd9);
    step();

    // Overflow: ten captures with the output stalled.
    rec_ready = 1'b0;
    out_aktv  = 3'b001;
    repeat (10) step();
    out_aktv = '0;
    chk("ovf_level", 64'(a_lvl), 64'd8);
    chk("ovf_flag", 64'(a_ovf), 64'd1);
    chk("ovf_drop", 64'(a_drop), 64'd1);

    // Full FIFO, FSM back in idle, capture on the popping edge.
    rec_ready = 1'b1;
    step();
    step();
    out_aktv = 3'b001;
    step();
    out_aktv = '0;
    chk("fullpop_level", 64'(a_lvl), 64'd8);
    chk("fullpop_drop", 64'(a_drop), 64'd1);
    repeat (40) step();
    chk("drain_level", 64'(a_lvl), 64'd0);

    // Reset while a record is mid-flight, then ts restarts from zero.
    out_aktv = 3'b101;
    step();
    out_aktv = '0;
    step();
    step();
    #2 rst = 1'b0;
    model_reset();
    #1 chk_reset_state("midrst");
    #3 rst = 1'b1;
    repeat (16) step();
    out_aktv = 3'b101;
    step();
    out_aktv = '0;
    step();
    chk("rst_hdr_a", a_data, 64'h0000_0010_0000_0005);
    chk("rst_hdr_b", b_data, 64'h0000_0000_0000_0005);
    repeat (4) step();

    // Random traffic with stall bursts and enable gaps.
    for (int k = 0; k < 3000; k++) begin
      en        = ($urandom % 4) != 0;
      out_aktv  = ($urandom % 3 == 0) ? 3'b000 : 3'($urandom);
      out_value = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (k % 400 < 100) rec_ready = ($urandom % 8) == 0;
      else               rec_ready = ($urandom % 3) != 0;
      step();
    end

    // Drain with en low; active flags must be ignored.
    en        = 1'b0;
    rec_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      out_aktv = 3'($urandom);
      step();
    end
    chk("final_empty", 64'(a_lvl), 64'd0);
    chk("final_idle", 64'(a_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
